mioc_odbus_arb: RTL and testbench

//  Sequences access to a shared open-drain, wired-AND/NOR MOS line (nand4_nor2-style gate

---
 rtl/mioc_odbus_pkg.sv | 17 +
 rtl/mioc_rr_pick.sv | 29 ++
 rtl/mioc_odbus_arb.sv | 155 +++++++++++++++
 tb/tb_mioc_odbus_arb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mioc_odbus_pkg.sv
// rtl/mioc_odbus_pkg.sv - shared state encoding and counter widths for the open-drain bus arbiter
package mioc_odbus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER   = 2'd1;
    localparam logic [1:0] ST_PRECHG = 2'd2;

    localparam int HOLD_W = 8;
    localparam int PRE_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_XFER   = ST_XFER,
        S_PRECHG = ST_PRECHG
    } odbus_state_e;

endpackage

// File: rtl/mioc_rr_pick.sv
// rtl/mioc_rr_pick.sv - combinational round-robin picker, first request at or above ptr (mod NREQ)
module mioc_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IDXW-1:0] win_idx,
    output logic            win_vld
);

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req[idx]) begin
                win_vld     = 1'b1;
                win_idx     = IDXW'(idx);
                win_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mioc_odbus_arb.sv
// rtl/mioc_odbus_arb.sv - open-drain shared-node arbiter: round-robin grant, hold timeout, precharge gap
// Build option MIOC_ODBUS_ARB_LOCK_EN adds a per-source lock input that suppresses the hold timeout.
module mioc_odbus_arb
    import mioc_odbus_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int HOLD_MAX  = 15,
    parameter int PRECHARGE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          done,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     drv_en,
    output logic                     busy,
    output logic                     timeout
`ifdef MIOC_ODBUS_ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]          lock
`endif
);

    localparam int IDXW = $clog2(NREQ);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'((PRECHARGE > 0) ? PRECHARGE - 1 : 0);

    odbus_state_e       state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0]    gnt_id_q, gnt_id_d;
    logic               drv_en_q, drv_en_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;

    logic [NREQ-1:0]    win_oh;
    logic [IDXW-1:0]    win_idx;
    logic               win_vld;
    logic               owner_rel;
    logic               owner_lock;
    logic               at_max;

    mioc_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Only the current owner's strobes matter; other sources are ignored while XFER.
    assign owner_rel = done[gnt_id_q] | ~req[gnt_id_q];
    assign at_max    = (hold_cnt_q == HOLD_LAST);

`ifdef MIOC_ODBUS_ARB_LOCK_EN
    assign owner_lock = lock[gnt_id_q];
`else
    assign owner_lock = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        drv_en_d   = drv_en_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d    = S_XFER;
                    gnt_d      = win_oh;
                    gnt_id_d   = win_idx;
                    drv_en_d   = 1'b1;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                    if (int'(win_idx) == NREQ - 1) rr_ptr_d = '0;
                    else                           rr_ptr_d = win_idx + 1'b1;
                end
            end
            S_XFER: begin
                // A normal release wins over a timeout landing on the same cycle.
                if (owner_rel || (at_max && !owner_lock)) begin
                    gnt_d     = '0;
                    drv_en_d  = 1'b0;
                    timeout_d = !owner_rel;
                    if (PRECHARGE > 0) begin
                        state_d   = S_PRECHG;
                        busy_d    = 1'b1;
                        pre_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (!at_max) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_PRECHG: begin
                if (pre_cnt_q == PRE_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                drv_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            drv_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            pre_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            drv_en_q   <= drv_en_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign drv_en  = drv_en_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mioc_odbus_arb.sv
// tb/tb_mioc_odbus_arb.sv - directed self-checking bench for mioc_odbus_arb (NREQ=4, HOLD_MAX=15, PRECHARGE=1)
module tb_mioc_odbus_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       drv_en;
    logic       busy;
    logic       timeout;
`ifdef MIOC_ODBUS_ARB_LOCK_EN
    logic [3:0] lock;
`endif

    int checks = 0;
    int errors = 0;

    mioc_odbus_arb #(
        .NREQ      (4),
        .HOLD_MAX  (15),
        .PRECHARGE (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .drv_en  (drv_en),
        .busy    (busy),
        .timeout (timeout)
`ifdef MIOC_ODBUS_ARB_LOCK_EN
        ,
        .lock    (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
`ifdef MIOC_ODBUS_ARB_LOCK_EN
        lock  = '0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int id;
        logic early_tmo;
        logic tmo_seen;

        do_reset();
        check("rst_gnt", gnt, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_drv_en", drv_en, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);

        // single requester, done release, one precharge cycle
        req = 4'b0010;
        tick();
        check("t1_gnt", gnt, 4'b0010);
        check("t1_gnt_id", gnt_id, 1);
        check("t1_drv_en", drv_en, 1);
        check("t1_busy", busy, 1);
        done = 4'b0010;
        tick();
        done = '0;
        req  = '0;
        check("t1_rel_gnt", gnt, 0);
        check("t1_rel_drv", drv_en, 0);
        check("t1_prechg_busy", busy, 1);
        tick();
        check("t1_idle_busy", busy, 0);

        // all requesting: round-robin 0,1,2,3,0 with a two-cycle gap
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            check("t2_gnt", gnt, 32'(4'b0001 << id));
            check("t2_gnt_id", gnt_id, id);
            tick();
            check("t2_hold", gnt, 32'(4'b0001 << id));
            done = 4'(4'b0001 << id);
            tick();
            done = '0;
            check("t2_gap1", gnt, 0);
            tick();
            check("t2_gap2", gnt, 0);
            tick();
        end

        // hold timeout after exactly 15 cycles, then req[3] wins
        do_reset();
        req = 4'b1100;
        tick();
        check("t3_gnt", gnt, 4'b0100);
        cnt = 1;
        early_tmo = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt != 4'b0100) break;
            cnt++;
            if (timeout) early_tmo = 1'b1;
        end
        check("t3_hold_len", cnt, 15);
        check("t3_early_tmo", early_tmo, 0);
        check("t3_timeout", timeout, 1);
        check("t3_drv_off", drv_en, 0);
        tick();
        check("t3_tmo_pulse", timeout, 0);
        tick();
        check("t3_next_gnt", gnt, 4'b1000);
        check("t3_next_id", gnt_id, 3);
        req = '0;
        tick();

        // done coincident with the 15th hold cycle: no timeout
        do_reset();
        req = 4'b0100;
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("t4_still_gnt", gnt, 4'b0100);
        done = 4'b0100;
        tick();
        done = '0;
        req  = '0;
        check("t4_rel", gnt, 0);
        check("t4_no_tmo", timeout, 0);
        tick();
        check("t4_no_tmo2", timeout, 0);

        // async reset mid-transfer, rr_ptr back to 0
        do_reset();
        req = 4'b0010;
        tick();
        check("t5_gnt", gnt, 4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt", gnt, 0);
        check("t5_async_drv", drv_en, 0);
        check("t5_async_busy", busy, 0);
        req = '0;
        tick();
        rst_n = 1'b1;
        req = 4'b1001;
        tick();
        check("t5_ptr0_gnt", gnt, 4'b0001);
        check("t5_ptr0_id", gnt_id, 0);
        req = '0;
        tick();
        tick();
        req = 4'b1000;
        tick();
        check("t5_gnt3", gnt, 4'b1000);
        check("t5_id3", gnt_id, 3);

`ifdef MIOC_ODBUS_ARB_LOCK_EN
        // lock suppresses timeout; dropping it forces release
        do_reset();
        lock = 4'b0001;
        req  = 4'b0001;
        tick();
        early_tmo = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (timeout) early_tmo = 1'b1;
            if (gnt == 4'b0001) cnt++;
        end
        check("t6_locked_no_tmo", early_tmo, 0);
        check("t6_locked_hold", cnt, 40);
        lock = '0;
        tmo_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (timeout) begin
                tmo_seen = 1'b1;
                break;
            end
        end
        check("t6_unlock_tmo", tmo_seen, 1);
        check("t6_unlock_gnt", gnt, 0);
        req = '0;
        tick();
`else
        tmo_seen = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
